// File: rtl/muldiv_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide unit.
// Decode uses the same op encodings (funct3 of the M instruction).
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, and final
// negation plus result selection on exit.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]        entry_op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg,
  input  logic [2:0]        exit_op,
  input  logic              exit_neg,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);

  logic              signed_a;
  logic              signed_b;
  logic              sign_a;
  logic              sign_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  always_comb begin
    signed_a = (entry_op == MULDIV_MUL) || (entry_op == MULDIV_MULH) ||
               (entry_op == MULDIV_MULHSU) || (entry_op == MULDIV_DIV) ||
               (entry_op == MULDIV_REM);
    signed_b = (entry_op == MULDIV_MUL) || (entry_op == MULDIV_MULH) ||
               (entry_op == MULDIV_DIV) || (entry_op == MULDIV_REM);
    sign_a   = signed_a & rs1[XLEN-1];
    sign_b   = signed_b & rs2[XLEN-1];
    mag_a    = sign_a ? (~rs1 + 1'b1) : rs1;
    mag_b    = sign_b ? (~rs2 + 1'b1) : rs2;
    // Remainder follows the dividend; everything else follows the sign product.
    neg      = (entry_op == MULDIV_REM || entry_op == MULDIV_REMU) ? sign_a
                                                                   : (sign_a ^ sign_b);
  end

  always_comb begin
    prod = exit_neg ? (~acc + 1'b1) : acc;
    quot = exit_neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem  = exit_neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (exit_op)
      MULDIV_MUL:                result = prod[XLEN-1:0];
      MULDIV_MULH, MULDIV_MULHSU,
      MULDIV_MULHU:              result = prod[2*XLEN-1:XLEN];
      MULDIV_DIV, MULDIV_DIVU:   result = quot;
      default:                   result = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, 32 CALC cycles, with single-cycle special cases.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic [XLEN-1:0]   mag_a, mag_b, fix_result;
  logic              fix_neg;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] acc_step;
  logic              special;
  logic [XLEN-1:0]   special_val;

  muldiv_sign_fix u_sign_fix (
    .entry_op (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg      (fix_neg),
    .exit_op  (op_q),
    .exit_neg (neg_q),
    .acc      (acc_step),
    .result   (fix_result)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_rem = acc_q[2*XLEN-1:XLEN-1];
    div_ge  = div_rem >= {1'b0, opb_q};
    div_sub = div_rem[XLEN-1:0] - opb_q;
    if (op_q[2]) begin
      acc_step = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                        : {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (op[2]) begin
      if (rs2 == '0) begin
        special     = 1'b1;
        special_val = op[1] ? rs1 : 32'hFFFF_FFFF;
      end else if ((op == MULDIV_DIV || op == MULDIV_REM) &&
                   rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) begin
        special     = 1'b1;
        special_val = op[1] ? 32'h0 : 32'h8000_0000;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          neg_d = fix_neg;
          cnt_d = 5'(ITER - 1);
          if (special) begin
            result_d = special_val;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else begin
            acc_d   = op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opb_d   = op[2] ? mag_b : mag_a;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          result_d = fix_result;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: driver tasks push expected results into a
// queue, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Clock / reset
  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op_i),
    .rs1    (rs1_i),
    .rs2    (rs2_i),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", result, mon_exp);
      end
    end
  end

  // Driver: issue one op, measure latency, then try a start in the done cycle.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    int busy_low;
    @(posedge clk); #1;
    op_i = o; rs1_i = a; rs2_i = b; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    op_i  = 3'($urandom_range(0, 7));
    rs1_i = $urandom;
    rs2_i = $urandom;
    cyc = 1;
    busy_low = 0;
    while (!done && cyc < 100) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(lat));
    check({name, "_busy_done"}, {31'b0, busy}, 32'h1);
    check({name, "_busy_gap"}, 32'(busy_low), 32'h0);
    start = 1'b1; op_i = MULDIV_MUL; rs1_i = 32'd1; rs2_i = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_idle_after"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cycles(3);
    rst_n = 1'b1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);

    run_op("mul_7_m3",     MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mul_big",      MULDIV_MUL,    32'h1234_5678,  32'd9,         32'hA3D7_0A38, 33);
    run_op("mulhu_m1",     MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh_m1",      MULDIV_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu_m1_2",  MULDIV_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_m20_6",    MULDIV_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 33);
    run_op("rem_m20_6",    MULDIV_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 33);
    run_op("divu_100_7",   MULDIV_DIVU,   32'd100,        32'd7,         32'd14,        33);
    run_op("remu_100_7",   MULDIV_REMU,   32'd100,        32'd7,         32'd2,         33);
    run_op("div_5_0",      MULDIV_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_5_0",      MULDIV_REM,    32'd5,          32'd0,         32'd5,         1);
    run_op("div_ovf",      MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",      MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
    run_op("divu_5_0",     MULDIV_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_7_0",     MULDIV_REMU,   32'd7,          32'd0,         32'd7,         1);

    // Flush mid-DIVU with an ignored start at T+5; result keeps 7 from above.
    @(posedge clk); #1;
    op_i = MULDIV_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cycles(4);
    op_i = MULDIV_MUL; rs1_i = 32'd2; rs2_i = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("flush_busy_t6", {31'b0, busy}, 32'h1);
    wait_cycles(4);
    check("flush_busy_t10", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_t11", {31'b0, busy}, 32'h0);
    check("flush_done_t11", {31'b0, done}, 32'h0);
    check("flush_result", result, 32'd7);
    wait_cycles(40);
    check("flush_still_idle", {31'b0, busy}, 32'h0);
    check("flush_result_kept", result, 32'd7);

    // Asynchronous reset in the middle of a MUL.
    @(posedge clk); #1;
    op_i = MULDIV_MUL; rs1_i = 32'd5; rs2_i = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cycles(19);
    check("pre_reset_busy", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'h0);
    check("async_reset_done", {31'b0, done}, 32'h0);
    check("async_reset_result", result, 32'h0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(40);
    check("post_reset_idle", {31'b0, busy}, 32'h0);
    run_op("mul_3_4", MULDIV_MUL, 32'd3, 32'd4, 32'd12, 33);

    wait_cycles(3);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the RISC-V M-extension operations for the core's execute stage. It sits beside the integer ALU, accepts operands from decode/register read on a start pulse, and returns a 32-bit result to writeback after a fixed latency. While busy, it stalls the pipeline.

## Interface

- XLEN, 32, operand and result width; only 32 is supported.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock domain.
- start  in  1  request; sampled only in IDLE.
- op  in  3  funct3 of the M instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (dividend or multiplicand).
- rs2  in  XLEN  operand B (divisor or multiplier).
- flush  in  1  synchronous abort; returns the unit to IDLE.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  XLEN  final value; held until the next accepted start.

## Operation

- States: IDLE, CALC, DONE.
  - IDLE→CALC on start.
  - IDLE→DONE on start for a special case.
  - CALC→DONE after 32 iterations.
  - DONE→IDLE unconditionally.
- On start, op, rs1 and rs2 are captured. Inputs are ignored after that.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply:
  - Radix-2 shift-add on operand magnitudes, one bit per CALC cycle.
  - Product is 64 bits. It is negated on exit if the operand signs differ.
  - MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- Special cases (IDLE→DONE directly):
  - rs2==0 on DIV/DIVU: result 0xFFFFFFFF.
  - rs2==0 on REM/REMU: result rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
  - Multiply has no special cases.
- start while busy: ignored, no queueing.
- flush in any state: go to IDLE at the next edge. done is not raised, and result keeps its previous value. flush has priority over start in the same cycle.

## Timing

- Reset values: state IDLE, busy 0, done 0, result 0, all internal registers 0.
- Normal latency: start sampled at the edge ending cycle T.
  - busy is high during cycles T+1..T+33.
  - done is high only in cycle T+33.
  - result is valid from T+33 onward.
- Special-case latency: done and busy are high in cycle T+1 only.
- Back-to-back: start asserted in the done cycle is ignored. The earliest next acceptance is the cycle after done.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). No done is issued.
- Iteration counter is 5 bits. It counts 31 down to 0, and the CALC exit condition is the count reaching 0.
- No combinational path from inputs to outputs.

## Structure

- Shared package muldiv_pkg holds:
  - op encodings MULDIV_MUL…MULDIV_REMU;
  - the state enum (IDLE, CALC, DONE);
  - constant ITER=32.
- The core's decode stage imports the same op constants.
- One natural sub-module: muldiv_sign_fix. It is combinational and does operand magnitude conversion plus final result negation and selection. It is shared by entry and exit paths.
- Datapath: 64-bit accumulator/remainder register, 32-bit operand register, counter, and result register.

## Test plan

- MUL rs1=7, rs2=−3 (0xFFFFFFFD), start in T → result 0xFFFFFFEB; done only in T+33; busy high T+1..T+33.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU rs1=−1, rs2=2 → 0xFFFFFFFF.
- DIV rs1=−20, rs2=6 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFE. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, done in T+1. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- flush in cycle T+10 of a DIVU → busy 0 from T+11, no done, result unchanged. start asserted at T+5 mid-operation is ignored.
- rst_n pulsed low at T+20 → busy, done and result all 0 immediately. A new MUL 3×4 after release → 12 after 33 cycles.
